rf_write_buffer: RTL
====================

// Module: rf_write_buffer
// PURPOSE
//  Write-side initiator for the register file. Queues (addr,data) results from multi-cycle producers (mult/div).
//  Drains them into the RF write port in cycles where the main datapath does not write.
//  Datapath writes pass through with priority.
//  A datapath write kills older queued writes to the same register, so program order of the final values holds.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >=2
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
// PORTS
//  clk                input   1       rising-edge clock, single domain
//  rst_n              input   1       synchronous, active-low reset
//  in_valid           input   1       producer has a write pending
//  in_ready           output  1       queue can accept this cycle
//  in_addr            input   ADDR_W  producer destination register
//  in_data            input   DATA_W  producer result
//  dp_reg_write       input   1       datapath write strobe (priority)
//  dp_write_register  input   ADDR_W  datapath destination
//  dp_write_data      input   DATA_W  datapath data
//  rf_reg_write       output  1       RF write enable
//  rf_write_register  output  ADDR_W  RF write address
//  rf_write_data      output  DATA_W  RF write data
//  pending_cnt        output  log2(DEPTH)+1  stored entries, live or dead
//  busy               output  1       pending_cnt != 0
// BEHAVIOUR
//  - Reset: rst_n sampled low at posedge clears pointers, count and all entry valid bits.
//    After reset: in_ready=1, pending_cnt=0, busy=0.
//    rf_reg_write=0 in every cycle rst_n is low.
//  - Enqueue: on posedge when in_valid & in_ready.
//    in_ready = (pending_cnt != DEPTH); no same-cycle push-on-full even if a pop occurs.
//  - in_addr==0 with in_valid & in_ready: handshake completes, nothing stored ($zero is never written).
//  - RF port mux, combinational:
//    - dp_reg_write=1: rf_* = dp_*.
//    - else head present and live: rf_reg_write=1, rf_* = head entry.
//    - else rf_reg_write=0.
//  - Pop head on posedge when it is dead, or when it is live and dp_reg_write=0.
//    Dead entries are discarded without an RF write.
//  - Min latency in->RF write: 1 cycle. Entry enqueued at edge N drives the RF in cycle N..N+1 if the datapath is idle.
//  - Kill: on posedge with dp_reg_write=1 and dp_write_register!=0, every already-stored live entry with a matching addr becomes dead.
//  - Same-cycle enqueue to that address is younger than the datapath write: stored live, not killed.
//  - Simultaneous enqueue and pop: both take effect; pending_cnt is unchanged.
//  - Pointers wrap modulo DEPTH.
//  - pending_cnt counts dead entries until they are popped.
// CONFIGURATION
//  RFWB_BYPASS_EN defined: adds ports for RF read-port forwarding.
//    - byp_addr1/byp_addr2 in ADDR_W, byp_hit1/byp_hit2 out 1, byp_data1/byp_data2 out DATA_W.
//    - hit=1 when the youngest live stored entry matches a nonzero address; data = that entry's data; combinational.
//    - A datapath write in the same cycle is not forwarded here.
//  RFWB_BYPASS_EN undefined: bypass ports and compare logic are absent.
//    Readers must stall while busy=1 (pipeline control's duty).
// STRUCTURE
//  - Package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, REG_ZERO=5'd0.
//    Also typedef struct packed {logic live; logic [4:0] addr; logic [31:0] data;} rf_wb_entry_t.
//  - One sub-module, rfwb_entry_store: DEPTH-entry array with wr/rd pointers, count and per-entry kill-compare.
//  - Top-level holds the handshake, the RF port mux and the optional bypass search.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid=1, dp_reg_write=1 -> rf_reg_write=0, in_ready=1.
//     After release, pending_cnt=0.
//  2. Idle drain: push (3,0xAAAA0003), dp idle -> next cycle rf_reg_write=1, addr=3, data=0xAAAA0003.
//     Then pending_cnt=0.
//  3. Priority: queue holds (5,0x55); dp_reg_write=1 to reg 7 for 3 cycles.
//     -> RF sees reg 7 for 3 cycles, then reg 5 = 0x55.
//  4. Full: push 4 entries with dp busy -> in_ready=0 and the 5th push is held.
//     Release dp -> in order, one write per cycle; the 5th is accepted once a slot frees.
//  5. Kill: queue holds (9,0x1); dp writes reg 9 = 0x2 -> reg 9 is never written 0x1.
//     Dead pop takes a cycle with rf_reg_write driven only by dp.
//  6. Zero/bypass: push (0,0xFFFF) -> no store, pending_cnt=0.
//     With RFWB_BYPASS_EN, queue (4,0x10),(4,0x20) and byp_addr1=4 -> byp_hit1=1, byp_data1=0x20.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file widths and entry payload for the RF write buffer.
package rf_pkg;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wb_entry_t;
endpackage

// File: rtl/rfwb_entry_store.sv
// DEPTH-entry circular store of pending RF writes with per-entry kill compare.
// RFWB_BYPASS_EN exposes the raw entry array for forwarding.
module rfwb_entry_store
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [ADDR_W-1:0]        kill_addr,
`ifdef RFWB_BYPASS_EN
  output logic [DEPTH-1:0]         ent_live,
  output logic [ADDR_W-1:0]        ent_addr [DEPTH],
  output logic [DATA_W-1:0]        ent_data [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head_ptr,
`endif
  output logic                     head_live,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH-1:0]  live;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Live bits stay clear for unoccupied slots, so the head bit alone says "present and live".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live[i] && (addr_q[i] == kill_addr)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        live[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload needs no reset: it is only observed through a live bit.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_live = live[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

`ifdef RFWB_BYPASS_EN
  assign ent_live = live;
  assign ent_addr = addr_q;
  assign ent_data = data_q;
  assign head_ptr = rd_ptr;
`endif
endmodule

// File: rtl/rf_write_buffer.sv
// Queues multi-cycle producer results and drains them into the RF write port when the datapath is idle.
// Optional RFWB_BYPASS_EN adds read-port forwarding from the youngest live queued entry.
module rf_write_buffer
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   dp_reg_write,
  input  logic [ADDR_W-1:0]      dp_write_register,
  input  logic [DATA_W-1:0]      dp_write_data,
`ifdef RFWB_BYPASS_EN
  input  logic [ADDR_W-1:0]      byp_addr1,
  input  logic [ADDR_W-1:0]      byp_addr2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_data1,
  output logic [DATA_W-1:0]      byp_data2,
`endif
  output logic                   rf_reg_write,
  output logic [ADDR_W-1:0]      rf_write_register,
  output logic [DATA_W-1:0]      rf_write_data,
  output logic [$clog2(DEPTH):0] pending_cnt,
  output logic                   busy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic              push, pop, kill_en, head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign in_ready = (pending_cnt != CNT_W'(DEPTH));
  assign busy     = (pending_cnt != '0);
  // Writes to $zero complete the handshake but are dropped.
  assign push     = in_valid && in_ready && (in_addr != ZERO_A);
  assign pop      = busy && (!head_live || !dp_reg_write);
  assign kill_en  = dp_reg_write && (dp_write_register != ZERO_A);

`ifdef RFWB_BYPASS_EN
  logic [DEPTH-1:0]  ent_live;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head_ptr;
`endif

  rfwb_entry_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (in_addr),
    .push_data (in_data),
    .pop       (pop),
    .kill_en   (kill_en),
    .kill_addr (dp_write_register),
`ifdef RFWB_BYPASS_EN
    .ent_live  (ent_live),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .head_ptr  (head_ptr),
`endif
    .head_live (head_live),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (pending_cnt)
  );

  // RF port mux: datapath has priority, then a live head entry.
  always_comb begin
    rf_reg_write      = 1'b0;
    rf_write_register = head_addr;
    rf_write_data     = head_data;
    if (dp_reg_write) begin
      rf_reg_write      = 1'b1;
      rf_write_register = dp_write_register;
      rf_write_data     = dp_write_data;
    end else if (head_live) begin
      rf_reg_write = 1'b1;
    end
    if (!rst_n) rf_reg_write = 1'b0;
  end

`ifdef RFWB_BYPASS_EN
  // Scan oldest to youngest so the youngest live match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (ent_live[idx] && (byp_addr1 != ZERO_A) && (ent_addr[idx] == byp_addr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = ent_data[idx];
      end
      if (ent_live[idx] && (byp_addr2 != ZERO_A) && (ent_addr[idx] == byp_addr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = ent_data[idx];
      end
    end
  end
`endif
endmodule
